md_unit: RTL and testbench

Parametrised multiply/divide unit with HI/LO result registers for the five-stage pipeline's E stage. It accepts signed/unsigned multiply and divide plus direct HI/LO writes. It holds `busy` for a configurable number of cycles per operation so the hazard unit can stall dependent instructions. Results commit to HI/LO atomically at the end of the busy window.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and sizing helpers for the multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // Counter must hold the larger of the two cycle counts.
   function automatic int unsigned md_cnt_width(input int unsigned mult_cycles,
                                                input int unsigned div_cycles);
      int unsigned max_c;
      max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return $clog2(max_c + 1);
   endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers; results are computed at accept,
// held in pending registers and committed atomically when the busy window ends.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
   localparam int unsigned W2 = 2 * WIDTH;

   md_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic             busy_q, busy_d;

   logic is_mul_c, is_div_c, is_signed_c, is_mthi_c, is_mtlo_c;

   always_comb begin
      is_mul_c    = 1'b0;
      is_div_c    = 1'b0;
      is_signed_c = 1'b0;
      is_mthi_c   = 1'b0;
      is_mtlo_c   = 1'b0;
      case (op)
         MD_MULT:  begin is_mul_c = 1'b1; is_signed_c = 1'b1; end
         MD_MULTU: is_mul_c = 1'b1;
         MD_DIV:   begin is_div_c = 1'b1; is_signed_c = 1'b1; end
         MD_DIVU:  is_div_c = 1'b1;
         MD_MTHI:  is_mthi_c = 1'b1;
         MD_MTLO:  is_mtlo_c = 1'b1;
         default:  ;
      endcase
   end

   // Low 2W bits of the sign/zero-extended product give the exact full product.
   logic [W2-1:0] a_ext_c, b_ext_c, prod_c;
   assign a_ext_c = is_signed_c ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext_c = is_signed_c ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod_c  = a_ext_c * b_ext_c;

   // Signed divide via magnitudes; MIN / -1 wraps back to MIN with zero remainder.
   logic             a_neg_c, b_neg_c, div_zero_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c, divisor_c, quo_u_c, rem_u_c, quo_c, rem_c;
   assign a_neg_c    = is_signed_c & a[WIDTH-1];
   assign b_neg_c    = is_signed_c & b[WIDTH-1];
   assign div_zero_c = (b == '0);
   assign a_mag_c    = a_neg_c ? (~a + WIDTH'(1)) : a;
   assign b_mag_c    = b_neg_c ? (~b + WIDTH'(1)) : b;
   assign divisor_c  = div_zero_c ? WIDTH'(1) : b_mag_c;
   assign quo_u_c    = a_mag_c / divisor_c;
   assign rem_u_c    = a_mag_c % divisor_c;
   assign quo_c      = (a_neg_c ^ b_neg_c) ? (~quo_u_c + WIDTH'(1)) : quo_u_c;
   assign rem_c      = a_neg_c ? (~rem_u_c + WIDTH'(1)) : rem_u_c;

   // The commit edge doubles as an accept slot so back-to-back ops leave no gap.
   logic last_c, acc_md_c, acc_mt_c;
   assign last_c   = (state_q == ST_RUN) && (cnt_q == CW'(1));
   assign acc_md_c = start && (is_mul_c || is_div_c) && ((state_q == ST_IDLE) || last_c);
   assign acc_mt_c = start && (state_q == ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (acc_md_c) state_d = ST_RUN;
         ST_RUN:  if (last_c)   state_d = acc_md_c ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      if (state_q == ST_RUN) cnt_d = cnt_q - CW'(1);
      if (last_c && pend_wr_q) begin
         hi_d = pend_hi_q;
         lo_d = pend_lo_q;
      end
      if (acc_md_c) begin
         cnt_d     = is_mul_c ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
         pend_wr_d = is_mul_c | ~div_zero_c;
         pend_hi_d = is_mul_c ? prod_c[W2-1:WIDTH] : rem_c;
         pend_lo_d = is_mul_c ? prod_c[WIDTH-1:0]  : quo_c;
      end
      if (acc_mt_c && is_mthi_c) hi_d = a;
      if (acc_mt_c && is_mtlo_c) lo_d = a;
      busy_d = (state_d == ST_RUN);
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected commits, a negedge
// monitor measures each busy window and compares HI/LO after it closes.
module tb_md_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic [31:0] hi, lo;

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
      logic        busy_after;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mon_cnt = 0;
   bit   mon_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: count busy cycles; the sample after the Nth busy cycle is the commit view.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon_cnt  = 0;
            mon_pend = 1'b0;
         end else if (mon_pend) begin
            e = exp_q.pop_front();
            check($sformatf("op%0d_hi", e.id), hi, e.hi);
            check($sformatf("op%0d_lo", e.id), lo, e.lo);
            check($sformatf("op%0d_busy_after", e.id), {31'd0, busy}, {31'd0, e.busy_after});
            mon_pend = 1'b0;
            mon_cnt  = busy ? 1 : 0;
            if (busy && exp_q.size() > 0 && exp_q[0].n == 1) mon_pend = 1'b1;
         end else if (busy) begin
            mon_cnt++;
            if (exp_q.size() > 0 && mon_cnt == exp_q[0].n) mon_pend = 1'b1;
         end else if (mon_cnt > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_len: busy dropped after %0d cycles, want %0d",
                     mon_cnt, (exp_q.size() > 0) ? exp_q[0].n : 0);
            mon_cnt = 0;
         end
      end
   end

   // Present an op for one edge; returns 1ns after the accept edge.
   task automatic drive(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: busy still 1 after 64 cycles, want 0");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int id, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi,
                         input logic [31:0] elo, input int n);
      exp_q.push_back('{id, ehi, elo, n, 1'b0});
      drive(o, av, bv);
      wait_done();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_op(1, MD_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
      run_op(2, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
      run_op(3, MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

      drive(MD_MTHI, 32'h11, 32'd0);
      check("mthi_hi", hi, 32'h11);
      check("mthi_lo_kept", lo, 32'hFFFF_FFFD);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      drive(MD_MTLO, 32'h22, 32'd0);
      check("mtlo_lo", lo, 32'h22);
      check("mtlo_hi_kept", hi, 32'h11);

      run_op(6, MD_DIVU, 32'd7, 32'd0, 32'h11, 32'h22, 10);
      run_op(7, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);

      drive(MD_MTHI, 32'h1234, 32'd0);
      check("mthi2_hi", hi, 32'h1234);
      check("mthi2_lo_kept", lo, 32'h8000_0000);
      @(negedge clk);
      check("mthi2_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // Operand changes and a stray start mid-busy must not disturb the MULT.
      exp_q.push_back('{9, 32'd0, 32'd12, 5, 1'b1});
      drive(MD_MULT, 32'd3, 32'd4);
      @(posedge clk);
      #1;
      start = 1'b1;
      op    = MD_MTLO;
      a     = 32'd100;
      b     = 32'd100;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("midbusy_lo_kept", lo, 32'h8000_0000);
      check("midbusy_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      exp_q.push_back('{10, 32'd0, 32'd6, 5, 1'b0});
      drive(MD_MULT, 32'd2, 32'd3);
      wait_done();

      // Abort a DIV in its third busy cycle.
      drive(MD_DIV, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_op(12, MD_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 5);

      repeat (2) @(posedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
